// File: rtl/mem_reader_pkg.sv
// mem_reader_pkg: shared types and constants for the thread-region memory reader.
//   state_t       - reader FSM states
//   fifo_entry_t  - one output buffer slot (data word + last-word flag)
//   FIFO_DEPTH    - output buffer depth
//   LEN_W         - width of the request word count
//
// The address-width macros normally arrive from the shared md5.vh header.
// The guarded values below are used only when that header has not already
// been read into the compilation unit.
`ifndef MEM_ADDR_MSB
`define MEM_ADDR_MSB 7
`endif
`ifndef MEM_TOTAL_MSB
`define MEM_TOTAL_MSB 11
`endif
`ifndef MSB
`define MSB(x) ($clog2((x) + 1) - 1)
`endif

package mem_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } fifo_entry_t;

    localparam int FIFO_DEPTH = 2;
    localparam int LEN_W      = 4;

endpackage

// File: rtl/mem_reader_if.sv
// mem_reader_if: request and output-stream handshake bundle of mem_reader.
//   req_*   - read request (valid/ready, thread, start address, word count)
//   out_*   - streamed words (valid/ready, data, last-word flag)
// modport master: requester / consumer side
// modport slave : mem_reader side
interface mem_reader_if #(
    parameter int TN_MSB = 3
) ();

    logic                    req_valid;
    logic                    req_ready;
    logic [TN_MSB:0]         req_thread_num;
    logic [`MEM_ADDR_MSB:0]  req_addr;
    logic [3:0]              req_len;

    logic [31:0]             out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;

    modport master (
        output req_valid, req_thread_num, req_addr, req_len, out_ready,
        input  req_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  req_valid, req_thread_num, req_addr, req_len, out_ready,
        output req_ready, out_data, out_valid, out_last
    );

endinterface

// File: rtl/mem_reader_fifo.sv
// mem_reader_fifo: 2-entry output buffer between the memory read port and
// the output stream.
//   CLK, RESET  - clock, synchronous active-high reset
//   push        - write push_entry this cycle
//   push_entry  - data word + last flag
//   pop         - consumer took the head entry this cycle
//   head        - oldest entry (valid when count != 0)
//   count       - occupancy, 0..2
// A simultaneous push and pop leaves occupancy unchanged. The caller never
// pushes into a full buffer.
module mem_reader_fifo
    import mem_reader_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        push,
    input  fifo_entry_t push_entry,
    input  logic        pop,
    output fifo_entry_t head,
    output logic [1:0]  count
);

    fifo_entry_t slots [FIFO_DEPTH];
    logic        wr_ptr;
    logic        rd_ptr;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            slots[0] <= '0;
            slots[1] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (push) begin
                slots[wr_ptr] <= push_entry;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = slots[rd_ptr];

endmodule

// File: rtl/mem_reader.sv
// mem_reader: reads req_len consecutive words from one thread's region of a
// shared memory and streams them out through a 2-entry buffer.
//   CLK, RESET       - clock, synchronous active-high reset
//   bus (slave)      - request handshake and output word stream
//   rd_en, rd_addr   - memory read port, address = {thread, local address}
//   rd_din           - memory data, valid the cycle after rd_en
//   done             - one-cycle pulse when a request has fully drained
//   done_thread_num  - thread of the completed request (valid with done)
//   err              - sticky: a request wrapped inside its thread region
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for a request, req_ready high
// ST_READ  | issuing reads while words remain and the buffer has room
// ST_DRAIN | all reads issued; waiting for buffer empty and no read in flight
module mem_reader
    import mem_reader_pkg::*;
#(
    parameter int N_CORES       = 3,
    parameter int N_THREADS     = 4 * N_CORES,
    parameter int N_THREADS_MSB = `MSB(N_THREADS - 1)
) (
    input  logic                    CLK,
    input  logic                    RESET,
    mem_reader_if.slave             bus,
    output logic                    rd_en,
    output logic [`MEM_TOTAL_MSB:0] rd_addr,
    input  logic [31:0]             rd_din,
    output logic                    done,
    output logic [N_THREADS_MSB:0]  done_thread_num,
    output logic                    err
);

    state_t                 state;
    logic [N_THREADS_MSB:0] thread_q;
    logic [`MEM_ADDR_MSB:0] local_q;
    logic [LEN_W-1:0]       words_left;
    logic                   inflight;
    logic                   inflight_last;
    logic                   wrap_pend;
    logic                   err_q;

    fifo_entry_t            push_entry;
    fifo_entry_t            head;
    logic [1:0]             fifo_count;
    logic                   pop;
    logic [2:0]             occ;

    // Occupancy the buffer will have once this cycle's pop and the write of
    // last cycle's read land; a new read is only issued if it still fits.
    assign occ = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};

    // Outputs are forced low while RESET is high, not only after the edge.
    assign rd_en = ~RESET && (state == ST_READ) && (words_left != 4'd0)
                   && (occ < 3'd2);
    assign rd_addr = RESET ? '0 : {thread_q, local_q};

    assign bus.req_ready = ~RESET && (state == ST_IDLE);
    assign bus.out_valid = ~RESET && (fifo_count != 2'd0);
    assign bus.out_data  = RESET ? 32'd0 : head.data;
    assign bus.out_last  = bus.out_valid && head.last;
    assign pop           = bus.out_valid && bus.out_ready;

    assign done = ~RESET && (state == ST_DRAIN) && (fifo_count == 2'd0)
                  && ~inflight;
    assign done_thread_num = done ? thread_q : '0;
    assign err             = ~RESET && err_q;

    assign push_entry.data = rd_din;
    assign push_entry.last = inflight_last;

    mem_reader_fifo u_fifo (
        .CLK        (CLK),
        .RESET      (RESET),
        .push       (inflight),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (fifo_count)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= ST_IDLE;
            thread_q      <= '0;
            local_q       <= '0;
            words_left    <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            wrap_pend     <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            inflight      <= rd_en;
            inflight_last <= rd_en && (words_left == 4'd1);
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        thread_q   <= bus.req_thread_num;
                        local_q    <= bus.req_addr;
                        words_left <= bus.req_len;
                        wrap_pend  <= 1'b0;
                        state      <= (bus.req_len == 4'd0) ? ST_DRAIN : ST_READ;
                    end
                end
                ST_READ: begin
                    if (rd_en) begin
                        local_q    <= local_q + 1'b1;
                        words_left <= words_left - 4'd1;
                        // The read after one at the top address lands on
                        // local address 0 of the same region: flag it then.
                        if (local_q == '1) begin
                            wrap_pend <= 1'b1;
                        end
                        if (wrap_pend) begin
                            err_q <= 1'b1;
                        end
                        if (words_left == 4'd1) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if ((fifo_count == 2'd0) && !inflight) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_reader.sv
// tb_mem_reader: directed bench for mem_reader. A behavioural memory with
// one cycle of read latency answers rd_en; every streamed word is compared
// with the word the bench expects at that position of the request.
module tb_mem_reader;

    logic        CLK;
    logic        RESET;
    logic        rd_en;
    logic [11:0] rd_addr;
    logic [31:0] rd_din;
    logic        done;
    logic [3:0]  done_thread_num;
    logic        err;

    int n_checks;
    int n_errors;

    logic [31:0] mem [0:4095];

    mem_reader_if #(.TN_MSB(3)) bus ();

    mem_reader dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .bus             (bus),
        .rd_en           (rd_en),
        .rd_addr         (rd_addr),
        .rd_din          (rd_din),
        .done            (done),
        .done_thread_num (done_thread_num),
        .err             (err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) begin
        if (rd_en) rd_din <= mem[rd_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [3:0] th, input logic [7:0] addr, input int i);
        logic [7:0] a;
        a = addr + i[7:0];
        return mem[{th, a}];
    endfunction

    // Issue one request at cycle 0 and follow it until done.
    // stall bit c = 1 holds out_ready low in cycle c.
    task automatic run_req(input string name, input logic [3:0] th, input logic [7:0] addr,
                           input logic [3:0] len, input logic [31:0] stall,
                           input int exp_done, input int exp_first_rd,
                           input int exp_first_ov, input logic exp_err);
        int issued, popped, done_cyc, first_rd, first_ov;
        logic [3:0] done_th;
        logic [7:0] a;
        issued = 0; popped = 0; done_cyc = -1; first_rd = -1; first_ov = -1; done_th = '0;
        for (int c = 0; c < 40 && done_cyc < 0; c++) begin
            @(negedge CLK);
            bus.req_valid      = (c == 0);
            bus.req_thread_num = th;
            bus.req_addr       = addr;
            bus.req_len        = len;
            bus.out_ready      = (c < 32) ? ~stall[c] : 1'b1;
            #1;
            if (c == 0) check({name, ".rdy_c0"}, bus.req_ready, 1);
            if (c == 1) check({name, ".rdy_busy"}, bus.req_ready, 0);
            if (rd_en) begin
                a = addr + issued[7:0];
                check({name, ".rd_addr"}, rd_addr, {th, a});
                if (first_rd < 0) first_rd = c;
                issued++;
            end
            if (bus.out_valid) begin
                check({name, ".out_data"}, bus.out_data, exp_word(th, addr, popped));
                check({name, ".out_last"}, bus.out_last, (popped == int'(len) - 1));
                if (first_ov < 0) first_ov = c;
                if (bus.out_ready) popped++;
            end
            if (issued - popped > 2) check({name, ".occ"}, issued - popped, 2);
            if (done) begin
                done_cyc = c;
                done_th  = done_thread_num;
            end
        end
        bus.req_valid = 1'b0;
        bus.out_ready = 1'b1;
        check({name, ".done_cyc"}, done_cyc, exp_done);
        check({name, ".done_th"}, done_th, th);
        check({name, ".n_rd"}, issued, int'(len));
        check({name, ".n_out"}, popped, int'(len));
        check({name, ".first_rd"}, first_rd, exp_first_rd);
        check({name, ".first_ov"}, first_ov, exp_first_ov);
        check({name, ".err"}, err, exp_err);
        @(negedge CLK);
        #1;
        check({name, ".rdy_after"}, bus.req_ready, 1);
        check({name, ".quiet_after"}, {rd_en, bus.out_valid, done}, 3'b000);
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, ".rd_en"}, rd_en, 0);
        check({name, ".rd_addr"}, rd_addr, 0);
        check({name, ".out_valid"}, bus.out_valid, 0);
        check({name, ".out_last"}, bus.out_last, 0);
        check({name, ".out_data"}, bus.out_data, 0);
        check({name, ".done"}, done, 0);
        check({name, ".done_th"}, done_thread_num, 0);
        check({name, ".err"}, err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'hDEAD_0000 | i;
        mem[12'h000] = 32'h3433_3231;
        mem[12'h001] = 32'h3837_3635;
        mem[12'h002] = 32'h0000_0000;
        mem[12'h003] = 32'h0063_6261;
        mem[12'h004] = 32'hA0A0_0004;
        mem[12'h005] = 32'hA0A0_0005;
        mem[12'h006] = 32'hA0A0_0006;
        mem[12'h007] = 32'hA0A0_0007;
        mem[12'h1FF] = 32'h0024_3124;
        mem[12'h2FE] = 32'h22FE_0001;
        mem[12'h2FF] = 32'h22FF_0002;
        mem[12'h200] = 32'h2200_0003;
        mem[12'h300] = 32'h3300_0000;

        rd_din             = '0;
        RESET              = 1'b1;
        bus.req_valid      = 1'b0;
        bus.req_thread_num = '0;
        bus.req_addr       = '0;
        bus.req_len        = '0;
        bus.out_ready      = 1'b0;

        repeat (3) @(negedge CLK);
        #1;
        check("rst.req_ready", bus.req_ready, 0);
        check_zero_outputs("rst");
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("rst.rdy_first", bus.req_ready, 1);

        // Basic read of thread 0 words 0..3 with fixed constants first.
        check("pre.w0", mem[0], 32'h3433_3231);
        run_req("basic", 4'd0, 8'h00, 4'd4, 32'h0, 7, 1, 3, 1'b0);
        run_req("stall", 4'd0, 8'h00, 4'd4, 32'h0000_01F0, 12, 1, 3, 1'b0);
        run_req("len0", 4'd3, 8'h10, 4'd0, 32'h0, 1, -1, -1, 1'b0);
        run_req("top1", 4'd1, 8'hFF, 4'd1, 32'h0, 4, 1, 3, 1'b0);
        run_req("wrap", 4'd2, 8'hFE, 4'd3, 32'h0, 6, 1, 3, 1'b1);
        repeat (3) @(negedge CLK);
        #1;
        check("wrap.err_sticky", err, 1);

        // Reset in cycle 2 of a len-8 request.
        @(negedge CLK);
        bus.req_valid      = 1'b1;
        bus.req_thread_num = 4'd0;
        bus.req_addr       = 8'h00;
        bus.req_len        = 4'd8;
        bus.out_ready      = 1'b1;
        @(negedge CLK);
        bus.req_valid = 1'b0;
        #1;
        check("abort.rd_c1", rd_en, 1);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        check("abort.in_rst_rdy", bus.req_ready, 0);
        check_zero_outputs("abort.in_rst");
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("abort.rdy_after", bus.req_ready, 1);
        check_zero_outputs("abort.after");
        @(negedge CLK);
        #1;
        check("abort.no_stale", {rd_en, bus.out_valid, done}, 3'b000);
        run_req("again", 4'd0, 8'h00, 4'd4, 32'h0, 7, 1, 3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
